// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART RX path.
// Detects the start bit and runs the per-bit oversampling edge counter.
// Deserializes the frame from the sampling stage's majority-voted bit.
// Checks the parity bit and the stop bit, then presents the received
// word with a one-cycle strobe.
//
// Ports:
//   CLK          in   receive oversampling clock
//   RST          in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   Prescale     in   oversampling ratio (8/16/32), static during a frame
//   PAR_EN       in   frame carries a parity bit (latched at start detect)
//   PAR_TYP      in   0 even / 1 odd parity (latched at start detect)
//   sampled_bit  in   majority-voted bit from the sampling stage
//   edge_cnt     out  oversampling edge index within the current bit
//   data_samp_en out  enables the sampling stage (any non-idle state)
//   P_DATA       out  last good received word
//   data_valid   out  one-cycle strobe when P_DATA is updated
//   par_err      out  one-cycle strobe on parity mismatch
//   stp_err      out  one-cycle strobe on a zero stop bit
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [5:0]            edge_cnt,
  output logic                  data_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [5:0]            r_edge_cnt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_flag;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [2:0]            w_state_nxt;
  logic [5:0]            w_edge_cnt_nxt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_par_en_nxt;
  logic                  w_par_typ_nxt;
  logic                  w_par_flag_nxt;
  logic [DATA_WIDTH-1:0] w_p_data_nxt;
  logic                  w_data_valid_nxt;
  logic                  w_par_err_nxt;
  logic                  w_stp_err_nxt;
  logic                  w_bit_end;
  logic                  w_exp_par;

  // Last oversampling edge of the current bit; sampled_bit is settled here
  assign w_bit_end = (r_edge_cnt == 6'(Prescale - 6'd1));
  assign w_exp_par = (^r_shift) ^ r_par_typ;

  // State register and all datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= 6'd0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_flag   <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_edge_cnt   <= w_edge_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par_en     <= w_par_en_nxt;
      r_par_typ    <= w_par_typ_nxt;
      r_par_flag   <= w_par_flag_nxt;
      r_p_data     <= w_p_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_par_err    <= w_par_err_nxt;
      r_stp_err    <= w_stp_err_nxt;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt      = r_state;
    w_edge_cnt_nxt   = 6'd0;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_par_en_nxt     = r_par_en;
    w_par_typ_nxt    = r_par_typ;
    w_par_flag_nxt   = r_par_flag;
    w_p_data_nxt     = r_p_data;
    w_data_valid_nxt = 1'b0;
    w_par_err_nxt    = 1'b0;
    w_stp_err_nxt    = 1'b0;

    // Edge counter free-runs per bit outside IDLE, wrapping at bit end
    if (r_state != S_IDLE) begin
      w_edge_cnt_nxt = w_bit_end ? 6'd0 : (r_edge_cnt + 6'd1);
    end

    case (r_state)
      S_IDLE: begin
        if (!RX_IN) begin
          w_state_nxt    = S_START;
          w_par_en_nxt   = PAR_EN;
          w_par_typ_nxt  = PAR_TYP;
          w_par_flag_nxt = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          if (sampled_bit) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          // LSB arrives first, so shift in from the top
          w_shift_nxt   = {sampled_bit, r_shift[DATA_WIDTH-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          if (sampled_bit != w_exp_par) begin
            w_par_flag_nxt = 1'b1;
          end
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          // Single outcome per frame; a bad stop bit masks a parity error
          if (!sampled_bit) begin
            w_stp_err_nxt = 1'b1;
          end else if (r_par_flag) begin
            w_par_err_nxt = 1'b1;
          end else begin
            w_p_data_nxt     = r_shift;
            w_data_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign edge_cnt     = r_edge_cnt;
  assign data_samp_en = (r_state != S_IDLE);
  assign P_DATA       = r_p_data;
  assign data_valid   = r_data_valid;
  assign par_err      = r_par_err;
  assign stp_err      = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a behavioural
// 3-sample majority-vote sampling stage in the loop.
module tb_uart_rx_ctrl;

  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [5:0]    Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          sampled_bit;
  logic [5:0]    edge_cnt;
  logic          data_samp_en;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc = -1, pe_cyc = -1, se_cyc = -1;
  int dv_hist[$];

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .edge_cnt     (edge_cnt),
    .data_samp_en (data_samp_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  always #5 CLK = ~CLK;

  // Edge index: value seen at a negedge equals the index of the preceding posedge
  always @(posedge CLK) cyc <= cyc + 1;

  // Sampling stage: votes edges P/2-1, P/2, P/2+1 and updates at P/2+1
  logic [1:0] smp;
  logic [5:0] half;
  assign half = Prescale >> 1;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp         <= 2'b00;
      sampled_bit <= 1'b1;
    end else if (data_samp_en) begin
      if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
      if (edge_cnt == half)        smp[1] <= RX_IN;
      if (edge_cnt == half + 6'd1)
        sampled_bit <= (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
    end
  end

  // Strobe monitor
  always @(negedge CLK) begin
    if (data_valid) begin dv_cnt++; dv_cyc = cyc; dv_hist.push_back(cyc); end
    if (par_err)    begin pe_cnt++; pe_cyc = cyc; end
    if (stp_err)    begin se_cnt++; se_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par_on,
                            input logic par_bit, input logic stop_bit, input int p);
    logic [DW-1:0] v;
    v = d;
    drive_bit(1'b0, p);
    for (int i = 0; i < int'(DW); i++) drive_bit(v[i], p);
    if (par_on) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    int t0, dv0, pe0, se0, c0;

    // Reset state
    idle(3);
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check("rst_samp_en",  32'(data_samp_en), 32'd0);
    check("rst_p_data",   32'(P_DATA), 32'd0);
    check("rst_dv",       32'(data_valid), 32'd0);
    check("rst_par_err",  32'(par_err), 32'd0);
    check("rst_stp_err",  32'(stp_err), 32'd0);
    RST = 1'b1;
    idle(5);

    // 1: P=8, no parity, 0xA5 -> strobe 80 CLK after start detect
    Prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; t0 = cyc + 1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    check("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t1_dv_time",  32'(dv_cyc), 32'(t0 + 80));
    check("t1_p_data",   32'(P_DATA), 32'hA5);
    check("t1_no_err",   32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
    check("t1_edge_idle", 32'(edge_cnt), 32'd0);
    check("t1_samp_en",  32'(data_samp_en), 32'd0);

    // 2a: P=16, even parity, 0x0F with parity bit 0 -> good at 176
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    idle(2);
    dv0 = dv_cnt; t0 = cyc + 1;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 16);
    idle(4);
    check("t2a_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t2a_dv_time",  32'(dv_cyc), 32'(t0 + 176));
    check("t2a_p_data",   32'(P_DATA), 32'h0F);

    // 2b: same frame with parity bit 1 -> par_err, data held
    dv0 = dv_cnt; pe0 = pe_cnt; t0 = cyc + 1;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 16);
    idle(4);
    check("t2b_pe_count", 32'(pe_cnt - pe0), 32'd1);
    check("t2b_pe_time",  32'(pe_cyc), 32'(t0 + 176));
    check("t2b_no_dv",    32'(dv_cnt - dv0), 32'd0);
    check("t2b_p_data",   32'(P_DATA), 32'h0F);

    // 3: P=8, odd parity, 0x01 with parity bit 0 -> good
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt; t0 = cyc + 1;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 8);
    idle(4);
    check("t3_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t3_dv_time",  32'(dv_cyc), 32'(t0 + 88));
    check("t3_p_data",   32'(P_DATA), 32'h01);

    // 3b: PAR_TYP flipped mid-frame must not change the outcome
    dv0 = dv_cnt; pe0 = pe_cnt;
    fork
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, 8);
      begin idle(20); PAR_TYP = 1'b0; end
    join
    idle(4);
    check("t3b_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t3b_no_pe",    32'(pe_cnt - pe0), 32'd0);
    PAR_TYP = 1'b1;

    // 4: 0x3C with stop=0, then 0xC3 immediately; detect of 2nd slips one CLK
    Prescale = 6'd8; PAR_EN = 1'b0;
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; c0 = cyc; t0 = cyc + 1;
    fork
      begin
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8);
      end
      begin
        idle(85);
        check("t4_p_data_held", 32'(P_DATA), 32'h01);
      end
    join
    idle(4);
    check("t4_se_count", 32'(se_cnt - se0), 32'd1);
    check("t4_se_time",  32'(se_cyc), 32'(t0 + 80));
    check("t4_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t4_dv_time",  32'(dv_cyc), 32'(c0 + 80 + 2 + 80));
    check("t4_p_data",   32'(P_DATA), 32'hC3);
    check("t4_no_pe",    32'(pe_cnt - pe0), 32'd0);

    // 5: P=16 glitch start: low 3 CLK then high -> abort at bit end
    Prescale = 6'd16;
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; c0 = cyc;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(13);
    check("t5_busy_before", 32'(data_samp_en), 32'd1);
    idle(1);
    check("t5_idle_after",  32'(data_samp_en), 32'd0);
    check("t5_edge_zero",   32'(edge_cnt), 32'd0);
    idle(20);
    check("t5_no_strobes",  32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // 6: P=32 back-to-back 0x55, 0xAA; spacing is one frame plus the re-arm CLK
    Prescale = 6'd32;
    idle(2);
    dv0 = dv_cnt; t0 = cyc + 1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 32);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 32);
    idle(4);
    check("t6_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("t6_dv_first", 32'(dv_hist[dv_hist.size()-2]), 32'(t0 + 320));
    check("t6_dv_gap",   32'(dv_hist[dv_hist.size()-1] - dv_hist[dv_hist.size()-2]), 32'd321);
    check("t6_p_data",   32'(P_DATA), 32'hAA);

    // 6b: reset during DATA of a third frame clears everything at once
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 16);
    check("t6_in_frame", 32'(data_samp_en), 32'd1);
    RST = 1'b0;
    #1;
    check("t6r_edge_cnt", 32'(edge_cnt), 32'd0);
    check("t6r_samp_en",  32'(data_samp_en), 32'd0);
    check("t6r_p_data",   32'(P_DATA), 32'd0);
    check("t6r_strobes",  32'({data_valid, par_err, stp_err}), 32'd0);
    RX_IN = 1'b1;
    idle(4);
    RST = 1'b1;
    idle(40);
    check("t6r_no_strobes", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // 6c: clean reception after the reset
    dv0 = dv_cnt; t0 = cyc + 1;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 32);
    idle(4);
    check("t6c_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t6c_dv_time",  32'(dv_cyc), 32'(t0 + 320));
    check("t6c_p_data",   32'(P_DATA), 32'h96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
